// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register pending-write busy bits.
// Reads are registered and see this edge's write/claim/flush (write-through bypass).
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDRW    = $clog2(NREGS),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD-1:0]       rd_en,
  input  logic [NREAD*ADDRW-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [ADDRW-1:0]       wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   claim_en,
  input  logic [ADDRW-1:0]       claim_addr,
  input  logic                   flush
);

  localparam logic ZeroEn = (ZERO_REG != 0);

  logic [XLEN-1:0]              regs [NREGS];
  logic [NREGS-1:0]             busy;
  logic [NREAD-1:0][ADDRW-1:0]  port_addr;
  logic [NREAD-1:0][XLEN-1:0]   port_data;
  logic [NREAD-1:0]             port_busy;
  logic                         wr_ok;
  logic                         claim_ok;

  assign port_addr = rd_addr;
  assign wr_ok     = wr_en && !(ZeroEn && (wr_addr == '0));
  // Flush beats a same-cycle claim, so a suppressed claim never reaches the array.
  assign claim_ok  = claim_en && !flush && !(ZeroEn && (claim_addr == '0));

  // Post-edge view of each addressed register: later assignments take priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    port_data = '0;
    port_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      port_data[i] = regs[port_addr[i]];
      port_busy[i] = busy[port_addr[i]];
      if (wr_ok && (wr_addr == port_addr[i])) begin
        port_data[i] = wr_data;
        port_busy[i] = 1'b0;
      end
      if (flush) port_busy[i] = 1'b0;
      if (claim_ok && (claim_addr == port_addr[i])) port_busy[i] = 1'b1;
      if (ZeroEn && (port_addr[i] == '0)) begin
        port_data[i] = '0;
        port_busy[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset because software may read any register before writing it.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy    <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later claim assignment overrides the write's clear.
      if (flush) busy <= '0;
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (claim_ok) busy[claim_addr] <= 1'b1;
      for (int i = 0; i < NREAD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= port_data[i];
          rd_busy[i]              <= port_busy[i];
        end
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a built-in pending-write scoreboard. It replaces the fixed 16-entry, two-port register file in the core's decode stage. Over the old block it adds synchronous posedge reads with write-through bypass, a configurable number of read ports, hardwired-zero handling, and per-register busy bits that issue logic uses to detect RAW hazards.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- ADDRW, 5, register address width, $clog2(NREGS)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register
- clk  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- rd_en  input  NREAD  per-port read enable
- rd_addr  input  NREAD*ADDRW  read addresses; port i occupies bits [i*ADDRW +: ADDRW]
- rd_data  output  NREAD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN]
- rd_busy  output  NREAD  registered busy flag of the register addressed on each port
- wr_en  input  1  write enable (writeback)
- wr_addr  input  ADDRW  write address
- wr_data  input  XLEN  write data
- claim_en  input  1  issue logic marks a destination register as pending
- claim_addr  input  ADDRW  register being claimed
- flush  input  1  clears all busy bits; register contents are unchanged

## Operation
- Storage: NREGS × XLEN data array and NREGS busy bits.
- Write, on posedge with wr_en=1: regs[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Claim, on posedge with claim_en=1: busy[claim_addr] ← 1.
- Claim and write to the same address in the same cycle: data is written and the busy bit ends at 1 (the newer producer wins).
- flush=1: all busy bits ← 0. flush wins over a same-cycle claim. Same-cycle writes still update data.
- ZERO_REG=1:
  - Writes and claims to address 0 are ignored.
  - Port reads of address 0 return 0 with busy 0.
- Read, port i, on posedge with rd_en[i]=1:
  - rd_data[i] ← regs_next[rd_addr[i]] and rd_busy[i] ← busy_next[rd_addr[i]].
  - regs_next and busy_next are the array values after this edge's write/claim/flush (write-through bypass).
- Read with rd_en[i]=0: rd_data[i] and rd_busy[i] hold their previous values.
- All ports are independent. Any number of ports may read the same address.
- Out-of-range addresses cannot occur because NREGS = 2^ADDRW.
- Reset (synchronous, active-high):
  - All registers, busy bits, rd_data and rd_busy ← 0.
  - Reset overrides any same-cycle wr_en, claim_en, rd_en or flush.
  - Reset asserted mid-stream discards pending claims.

## Timing
- Read latency: 1 cycle. Address is presented in cycle N; data is valid after posedge N and stays stable through cycle N+1.
- Write-to-read: a write and a read of the same address on the same edge returns the new data on that edge (0-cycle bypass).
- Claim-to-busy: a claim at edge N is visible on rd_busy of a port reading that address at edge N.
- Write clears busy at the same edge as the data update. A read on that edge sees busy=0 and the new data, unless a same-edge claim is present.
- No combinational path from any input to any output. All outputs are flops.
- Outputs after reset: rd_data=0 and rd_busy=0 on every port until the first enabled read.

## Test plan
- Reset and zero register:
  - Stimulus: assert reset for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xDEAD; then read ports 0 and 1 at addresses 3 and 0.
  - Required: rd_data=0 and rd_busy=0 on both ports.
  - Stimulus: write 0x1234 to address 0.
  - Required: a later read of address 0 returns 0 (ZERO_REG=1).
- Basic write/read and hold:
  - Stimulus: write 0xA5A5A5A5 to address 7, then read address 7 on port 1.
  - Required: 0xA5A5A5A5 appears 1 cycle later.
  - Stimulus: drop rd_en[1] and write 0x0 to address 7.
  - Required: rd_data[1] holds 0xA5A5A5A5.
- Bypass:
  - Stimulus: on the same edge, wr_addr=9, wr_data=0x55 and rd_addr[0]=9, rd_en[0]=1.
  - Required: rd_data[0]=0x55 after that edge, not the old value.
- Scoreboard:
  - Stimulus: claim address 12; read address 12 on the same edge.
  - Required: rd_busy=1.
  - Stimulus: write 12.
  - Required: the next read shows rd_busy=0 with the new data.
  - Stimulus: claim and write 12 on the same edge.
  - Required: rd_busy=1.
- Flush:
  - Stimulus: claim addresses 4, 5 and 6, then assert flush together with claim_en at address 8.
  - Required: reads of 4, 5, 6 and 8 all show busy=0; data unchanged.
- Parametrisation:
  - Stimulus: rebuild with NREAD=4, NREGS=16, ZERO_REG=0; write 0xF to address 0; read it on all four ports.
  - Required: all four ports return 0xF.
